// File: rtl/fpga_top_pkg.sv
// rtl/fpga_top_pkg.sv - state codes and constants for the FX2-to-Wishbone bridge
package fpga_top_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_CMD  = 4'd1,
    ST_WB_REQ  = 4'd2,
    ST_WB_WAIT = 4'd3,
    ST_WR_HI   = 4'd4,
    ST_WR_LO   = 4'd5,
    ST_PKEND   = 4'd6
  } state_e;

  localparam logic [1:0]  FIFO_EP2      = 2'b00;
  localparam logic [1:0]  FIFO_EP6      = 2'b10;
  localparam int          CMD_WRITE_BIT = 0;
  localparam int          PKT_WORDS     = 5;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;
  localparam logic [31:0] TIMEOUT_RESP  = 32'hDEAD_BEEF;

endpackage

// File: rtl/fpga_top_if.sv
// rtl/fpga_top_if.sv - pipelined Wishbone master bus bundle
interface fpga_top_if;
  logic        WB_RST;
  logic        WB_CYC;
  logic        WB_STB;
  logic        WB_WE;
  logic [3:0]  WB_SEL;
  logic [31:0] WB_ADDR;
  logic [31:0] WB_DATA_O;
  logic [31:0] WB_DATA_I;
  logic        WB_ACK;
  logic        WB_STALL;

  modport master (
    output WB_RST, WB_CYC, WB_STB, WB_WE, WB_SEL, WB_ADDR, WB_DATA_O,
    input  WB_DATA_I, WB_ACK, WB_STALL
  );

  modport slave (
    input  WB_RST, WB_CYC, WB_STB, WB_WE, WB_SEL, WB_ADDR, WB_DATA_O,
    output WB_DATA_I, WB_ACK, WB_STALL
  );
endinterface

// File: rtl/fpga_top_fifo_port.sv
// rtl/fpga_top_fifo_port.sv - fx2_fifo_port: registered FX2 strobes, bus tristate and transfer qualifiers
module fx2_fifo_port
  import fpga_top_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_d_i,
  input  logic        wr_en_d_i,
  input  logic        pkend_d_i,
  input  logic [15:0] wr_word_d_i,
  input  logic        flaga_i,
  input  logic        flagd_i,
  inout  wire  [15:0] usb_data_io,
  output logic [1:0]  usb_addr_o,
  output logic        slrd_o,
  output logic        slwr_o,
  output logic        sloe_o,
  output logic        pkend_o,
  output logic        rd_xfer_o,
  output logic        wr_xfer_o,
  output logic [15:0] rd_word_o
);

  logic        slrd_q, slwr_q, sloe_q, pkend_q, oe_q;
  logic [1:0]  addr_q;
  logic [15:0] dout_q;

  // Strobes follow the FSM's next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      slrd_q  <= 1'b1;
      slwr_q  <= 1'b1;
      sloe_q  <= 1'b1;
      pkend_q <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= FIFO_EP2;
      dout_q  <= '0;
    end else begin
      slrd_q  <= ~rd_en_d_i;
      sloe_q  <= ~rd_en_d_i;
      slwr_q  <= ~wr_en_d_i;
      pkend_q <= ~pkend_d_i;
      oe_q    <= wr_en_d_i;
      addr_q  <= (wr_en_d_i || pkend_d_i) ? FIFO_EP6 : FIFO_EP2;
      dout_q  <= wr_word_d_i;
    end
  end

  // Read and write enables come from the same state, so SLOE low and bus drive never overlap
  assign usb_data_io = oe_q ? dout_q : 16'hzzzz;
  assign rd_word_o   = usb_data_io;
  assign rd_xfer_o   = ~slrd_q & ~sloe_q & flaga_i;
  assign wr_xfer_o   = ~slwr_q & flagd_i;
  assign usb_addr_o  = addr_q;
  assign slrd_o      = slrd_q;
  assign slwr_o      = slwr_q;
  assign sloe_o      = sloe_q;
  assign pkend_o     = pkend_q;

endmodule

// File: rtl/fpga_top.sv
// rtl/fpga_top.sv - FX2 command packet to Wishbone bridge; FPGA_TOP_WB_TIMEOUT_EN enables the ACK timeout
module fpga_top
  import fpga_top_pkg::*;
(
  input  logic        USB_IFCLK,
  input  logic        RST,
  inout  wire  [15:0] USB_DATA,
  output logic [1:0]  USB_ADDR,
  output logic        USB_SLRD,
  output logic        USB_SLWR,
  output logic        USB_SLOE,
  output logic        USB_PKEND,
  input  logic        USB_FLAGA,
  input  logic        USB_FLAGD,
  output logic [15:0] BUFF0,
  output logic [15:0] BUFF1,
  output logic [15:0] BUFF2,
  output logic [15:0] BUFF3,
  output logic [15:0] BUFF4,
  output logic [3:0]  STATE,
  output logic [3:0]  LED,
  fpga_top_if.master  wb
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] buff_q [PKT_WORDS];
  logic [15:0] buff_d [PKT_WORDS];
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d, dato_q, dato_d, resp_q, resp_d;
  logic        led_tgl_q, led_tgl_d, led_wr_q, led_wr_d, led_busy_q, led_to;
  logic [15:0] wr_word_d, rd_word;
  logic        rd_xfer, wr_xfer;
`ifdef FPGA_TOP_WB_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        led_to_q, led_to_d;
`endif

  fx2_fifo_port u_port (
    .clk         (USB_IFCLK),
    .rst         (RST),
    .rd_en_d_i   (state_d == ST_RD_CMD),
    .wr_en_d_i   ((state_d == ST_WR_HI) || (state_d == ST_WR_LO)),
    .pkend_d_i   (state_d == ST_PKEND),
    .wr_word_d_i (wr_word_d),
    .flaga_i     (USB_FLAGA),
    .flagd_i     (USB_FLAGD),
    .usb_data_io (USB_DATA),
    .usb_addr_o  (USB_ADDR),
    .slrd_o      (USB_SLRD),
    .slwr_o      (USB_SLWR),
    .sloe_o      (USB_SLOE),
    .pkend_o     (USB_PKEND),
    .rd_xfer_o   (rd_xfer),
    .wr_xfer_o   (wr_xfer),
    .rd_word_o   (rd_word)
  );

  // Next state, command capture, Wishbone request/response and outgoing word selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buff_d    = buff_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dato_d    = dato_q;
    resp_d    = resp_q;
    led_tgl_d = led_tgl_q;
    led_wr_d  = led_wr_q;
    wr_word_d = 16'h0;
`ifdef FPGA_TOP_WB_TIMEOUT_EN
    to_cnt_d  = '0;
    led_to_d  = led_to_q;
`endif
    case (state_q)
      ST_IDLE: if (USB_FLAGA) state_d = ST_RD_CMD;
      ST_RD_CMD: begin
        if (rd_xfer) begin
          buff_d[cnt_q] = rd_word;
          if (cnt_q == 3'(PKT_WORDS - 1)) begin
            // Word 4 is still on the bus this edge, so data-lo comes straight from it
            cnt_d    = '0;
            state_d  = ST_WB_REQ;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            sel_d    = 4'hF;
            we_d     = buff_q[0][CMD_WRITE_BIT];
            adr_d    = {buff_q[1], buff_q[2]};
            dato_d   = {buff_q[3], rd_word};
            led_wr_d = buff_q[0][CMD_WRITE_BIT];
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_WB_REQ: begin
        if (!wb.WB_STALL) begin
          stb_d   = 1'b0;
          state_d = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (wb.WB_ACK) begin
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          resp_d  = we_q ? dato_q : wb.WB_DATA_I;
          state_d = ST_WR_HI;
        end
      end
      ST_WR_HI: if (wr_xfer) state_d = ST_WR_LO;
      ST_WR_LO: if (wr_xfer) state_d = ST_PKEND;
      ST_PKEND: begin
        state_d   = ST_IDLE;
        led_tgl_d = ~led_tgl_q;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef FPGA_TOP_WB_TIMEOUT_EN
    if ((state_q == ST_WB_REQ) || (state_q == ST_WB_WAIT)) begin
      to_cnt_d = to_cnt_q + 8'd1;
      if ((to_cnt_q == TIMEOUT_LIMIT - 8'd1) && !((state_q == ST_WB_WAIT) && wb.WB_ACK)) begin
        cyc_d    = 1'b0;
        stb_d    = 1'b0;
        sel_d    = 4'h0;
        resp_d   = TIMEOUT_RESP;
        state_d  = ST_WR_HI;
        led_to_d = 1'b1;
        to_cnt_d = '0;
      end
    end
`endif
    if (state_d == ST_WR_HI) wr_word_d = resp_d[31:16];
    else if (state_d == ST_WR_LO) wr_word_d = resp_d[15:0];
  end

  // State and datapath registers; reset discards any partial packet
  always_ff @(posedge USB_IFCLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      for (int i = 0; i < PKT_WORDS; i++) buff_q[i] <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= '0;
      dato_q     <= '0;
      resp_q     <= '0;
      led_tgl_q  <= 1'b0;
      led_wr_q   <= 1'b0;
      led_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buff_q     <= buff_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dato_q     <= dato_d;
      resp_q     <= resp_d;
      led_tgl_q  <= led_tgl_d;
      led_wr_q   <= led_wr_d;
      led_busy_q <= (state_d != ST_IDLE);
    end
  end

`ifdef FPGA_TOP_WB_TIMEOUT_EN
  // Timeout counter and sticky timeout flag
  always_ff @(posedge USB_IFCLK) begin
    if (RST) begin
      to_cnt_q <= '0;
      led_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      led_to_q <= led_to_d;
    end
  end
  assign led_to = led_to_q;
`else
  assign led_to = 1'b0;
`endif

  assign wb.WB_RST    = RST;
  assign wb.WB_CYC    = cyc_q;
  assign wb.WB_STB    = stb_q;
  assign wb.WB_WE     = we_q;
  assign wb.WB_SEL    = sel_q;
  assign wb.WB_ADDR   = adr_q;
  assign wb.WB_DATA_O = dato_q;
  assign BUFF0        = buff_q[0];
  assign BUFF1        = buff_q[1];
  assign BUFF2        = buff_q[2];
  assign BUFF3        = buff_q[3];
  assign BUFF4        = buff_q[4];
  assign STATE        = state_q;
  assign LED          = {led_to, led_wr_q, led_busy_q, led_tgl_q};

endmodule

// File: tb/tb_fpga_top.sv
// tb/tb_fpga_top.sv - self-checking bench for fpga_top with FIFO and Wishbone slave models
module tb_fpga_top;

  logic        clk;
  logic        rst;
  logic        flaga, flagd;
  logic [15:0] ep2_drive;
  wire  [15:0] usb_data;
  logic [1:0]  usb_addr;
  logic        slrd, slwr, sloe, pkend;
  logic [15:0] buff_o [5];
  logic [3:0]  dut_state, led;

  fpga_top_if wb ();

  fpga_top dut (
    .USB_IFCLK (clk),
    .RST       (rst),
    .USB_DATA  (usb_data),
    .USB_ADDR  (usb_addr),
    .USB_SLRD  (slrd),
    .USB_SLWR  (slwr),
    .USB_SLOE  (sloe),
    .USB_PKEND (pkend),
    .USB_FLAGA (flaga),
    .USB_FLAGD (flagd),
    .BUFF0     (buff_o[0]),
    .BUFF1     (buff_o[1]),
    .BUFF2     (buff_o[2]),
    .BUFF3     (buff_o[3]),
    .BUFF4     (buff_o[4]),
    .STATE     (dut_state),
    .LED       (led),
    .wb        (wb)
  );

  // The host side only drives the bus while the bridge has output-enable asserted
  assign usb_data = (!sloe) ? ep2_drive : 16'hzzzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] ep2_q [$];
  logic [15:0] in_q [$];
  int          pk_cnt, rd_count, gap_after, gap_left, flagd_gap;
  int          stall_left, ack_delay, ack_cnt, stb_cycles, cyc_cycles;
  bit          pending, never_ack;
  logic [31:0] rdata, exp_resp, cap_addr, cap_dato;
  logic        cap_we, exp_we, exp_to, led_tgl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: decide host/slave behaviour at the falling edge, apply the FIFO model after the rising edge
  task automatic step();
    bit rd_go, wr_go, pk_go;
    logic [15:0] wword;
    ep2_drive = (ep2_q.size() > 0) ? ep2_q[0] : 16'h0;
    flaga = (ep2_q.size() > 0);
    if (ep2_q.size() > 0 && rd_count == gap_after && gap_left > 0) begin
      flaga = 1'b0;
      gap_left--;
      chk("rd_strobes_hold", {30'b0, slrd, sloe}, 32'h0);
    end
    flagd = 1'b1;
    if (!slwr && in_q.size() == 0 && flagd_gap > 0) begin
      flagd = 1'b0;
      flagd_gap--;
      chk("wr_hold_data", usb_data, exp_resp[31:16]);
    end
    rd_go = !slrd && !sloe && flaga;
    wr_go = !slwr && flagd;
    pk_go = !pkend;
    wword = usb_data;
    wb.WB_ACK    = 1'b0;
    wb.WB_STALL  = 1'b0;
    wb.WB_DATA_I = rdata;
    if (wb.WB_CYC) cyc_cycles++;
    if (wb.WB_CYC && wb.WB_STB) begin
      stb_cycles++;
      chk("wb_sel", wb.WB_SEL, 4'hF);
      if (stall_left > 0) begin
        stall_left--;
        wb.WB_STALL = 1'b1;
      end else begin
        pending  = 1'b1;
        ack_cnt  = ack_delay;
        cap_addr = wb.WB_ADDR;
        cap_dato = wb.WB_DATA_O;
        cap_we   = wb.WB_WE;
      end
    end else if (wb.WB_CYC && pending && !never_ack) begin
      ack_cnt--;
      if (ack_cnt <= 0) begin
        wb.WB_ACK = 1'b1;
        pending   = 1'b0;
      end
    end
    @(posedge clk);
    if (rd_go) begin
      void'(ep2_q.pop_front());
      rd_count++;
    end
    if (wr_go) in_q.push_back(wword);
    if (pk_go) pk_cnt++;
    @(negedge clk);
  endtask

  task automatic run_packet(input logic [15:0] w [5], input logic [31:0] rd, input int stall,
                            input int ackd, input bit nack, input int ga, input int gl,
                            input int fdg, input bit lat);
    int steps;
    ep2_q.delete();
    in_q.delete();
    for (int i = 0; i < 5; i++) ep2_q.push_back(w[i]);
    rdata = rd; stall_left = stall; ack_delay = ackd; never_ack = nack; pending = 1'b0;
    gap_after = ga; gap_left = gl; flagd_gap = fdg;
    rd_count = 0; pk_cnt = 0; stb_cycles = 0; cyc_cycles = 0;
    exp_we   = w[0][0];
    exp_resp = nack ? 32'hDEAD_BEEF : (exp_we ? {w[3], w[4]} : rd);
    if (nack) exp_to = 1'b1;
    steps = 0;
    while (pk_cnt == 0 && steps < 2000) begin
      step();
      steps++;
      if (steps == 1) begin
        chk("state_rd_cmd", dut_state, 4'd1);
        chk("led_busy", led[1], 1'b1);
      end
    end
    chk("pkend_seen", pk_cnt, 1);
    if (lat) chk("latency", steps, 11);
    step();
    step();
    chk("pkend_single", pk_cnt, 1);
    chk("in_words", in_q.size(), 2);
    if (in_q.size() == 2) begin
      chk("resp_hi", in_q[0], exp_resp[31:16]);
      chk("resp_lo", in_q[1], exp_resp[15:0]);
    end
    chk("words_read", rd_count, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("buff%0d", i), buff_o[i], w[i]);
    chk("wb_addr", cap_addr, {w[1], w[2]});
    chk("wb_we", cap_we, w[0][0]);
    chk("wb_dato", cap_dato, {w[3], w[4]});
    chk("stb_cycles", stb_cycles, stall + 1);
    if (!nack) chk("cyc_cycles", cyc_cycles, stall + 1 + ackd);
    led_tgl = ~led_tgl;
    chk("led", led, {exp_to, exp_we, 1'b0, led_tgl});
    chk("state_idle", dut_state, 4'd0);
    chk("wb_cyc_idle", wb.WB_CYC, 1'b0);
  endtask

  initial begin
    logic [15:0] pkt [5];
    int n;
    rst = 1'b1; flaga = 1'b0; flagd = 1'b1; ep2_drive = 16'h0;
    wb.WB_ACK = 1'b0; wb.WB_STALL = 1'b0; wb.WB_DATA_I = 32'h0;
    rdata = 32'h0; exp_resp = 32'h0; gap_after = -1; gap_left = 0; flagd_gap = 0;
    stall_left = 0; ack_delay = 1; ack_cnt = 0; pending = 1'b0; never_ack = 1'b0;
    pk_cnt = 0; rd_count = 0; exp_we = 1'b0; exp_to = 1'b0; led_tgl = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_strobes", {slrd, slwr, sloe, pkend}, 4'hF);
    chk("rst_addr", usb_addr, 2'b00);
    chk("rst_wb_ctl", {wb.WB_CYC, wb.WB_STB, wb.WB_WE, wb.WB_SEL}, 7'h0);
    chk("rst_wb_addr", wb.WB_ADDR, 32'h0);
    chk("rst_wb_dato", wb.WB_DATA_O, 32'h0);
    chk("rst_buff0", buff_o[0], 16'h0);
    chk("rst_buff4", buff_o[4], 16'h0);
    chk("rst_state", dut_state, 4'd0);
    chk("rst_led", led, 4'h0);
    chk("wb_rst_hi", wb.WB_RST, 1'b1);
    rst = 1'b0;
    step();
    chk("wb_rst_lo", wb.WB_RST, 1'b0);

    pkt = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4};
    run_packet(pkt, 32'h1234_5678, 0, 1, 1'b0, -1, 0, 0, 1'b1);
    pkt = '{16'h1, 16'hA, 16'hB, 16'hC, 16'hD};
    run_packet(pkt, 32'h5555_AAAA, 0, 1, 1'b0, -1, 0, 0, 1'b1);
    pkt = '{16'h0, 16'h11, 16'h22, 16'h33, 16'h44};
    run_packet(pkt, 32'hCAFE_F00D, 0, 1, 1'b0, 2, 3, 4, 1'b0);
    pkt = '{16'h0, 16'h7, 16'h8, 16'h9, 16'hA};
    run_packet(pkt, 32'h0BAD_F00D, 2, 5, 1'b0, -1, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) pkt[i] = 16'($urandom);
      run_packet(pkt, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                 1'b0, -1, 0, 0, 1'b0);
    end

`ifdef FPGA_TOP_WB_TIMEOUT_EN
    pkt = '{16'h0, 16'h100, 16'h200, 16'h300, 16'h400};
    run_packet(pkt, 32'h0, 0, 1, 1'b1, -1, 0, 0, 1'b0);
`endif

    // Reset while the bridge waits for an ACK that never comes
    for (int i = 0; i < 5; i++) ep2_q.push_back(16'(i + 16'h50));
    in_q.delete();
    never_ack = 1'b1; pending = 1'b0; stall_left = 0; gap_after = -1; flagd_gap = 0; rd_count = 0;
    n = 0;
    while (!(wb.WB_CYC && !wb.WB_STB) && n < 50) begin
      step();
      n++;
    end
    chk("wait_reached", wb.WB_CYC && !wb.WB_STB, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_cyc", wb.WB_CYC, 1'b0);
    chk("mid_rst_state", dut_state, 4'd0);
    chk("mid_rst_strobes", {slrd, slwr, sloe, pkend}, 4'hF);
    chk("mid_rst_buff0", buff_o[0], 16'h0);
    rst = 1'b0;
    led_tgl = 1'b0; exp_to = 1'b0;
    step();
    chk("mid_rst_led", led, 4'h0);

    pkt = '{16'h1, 16'h3, 16'h5, 16'h7, 16'h9};
    run_packet(pkt, 32'h0, 1, 2, 1'b0, -1, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
